// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/MEM unified-memory port arbiter: FSM states, owner
// encodings and the fetch-vs-data arbitration rule.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    // Data normally wins a tie; a starved fetch takes the next slot.
    function automatic owner_t pick_owner(input logic if_req,
                                          input logic dm_req,
                                          input logic fetch_starved);
        owner_t winner;
        if (dm_req && !(if_req && fetch_starved)) begin
            winner = OWN_DM;
        end else begin
            winner = OWN_IF;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating starvation counter: counts consecutive lost arbitrations of a
// requester and flags when it has reached its limit.
module arb_starve_ctr #(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt;

    // Clear has priority; increment stops at MAX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != W'(MAX))) begin
            cnt <= cnt + W'(1);
        end else begin
            cnt <= cnt;
        end
    end

    assign at_max = (cnt == W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data
// stage: one outstanding transaction, response steering, timeout and starvation guard.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX   = 4,
    parameter int WAIT_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_wstrb,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        bus_err
);

    localparam int TW = $clog2(WAIT_TIMEOUT);

    arb_state_t    state, state_nxt;
    owner_t        owner, owner_nxt;
    logic          owner_we, owner_we_nxt;
    logic [TW-1:0] tmo_cnt;
    logic          starve_inc, starve_clr, starve_at_max;
    logic          owner_req;
    logic          tmo_hit;

    arb_starve_ctr #(.MAX(STARVE_MAX)) u_if_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .at_max (starve_at_max)
    );

    assign owner_req = (owner == OWN_DM) ? dm_req : if_req;
    assign tmo_hit   = (tmo_cnt == TW'(WAIT_TIMEOUT - 1));

    // State, owner and timeout registers; the timeout count is zero on WAIT entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= OWN_IF;
            owner_we <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            owner_we <= owner_we_nxt;
            tmo_cnt  <= (state == ST_WAIT) ? tmo_cnt + TW'(1) : '0;
        end
    end

    // Next-state logic plus the combinational request/response routing.
    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        owner_we_nxt = owner_we;
        starve_inc   = 1'b0;
        starve_clr   = 1'b0;
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = 32'h0000_0000;
        dm_gnt       = 1'b0;
        dm_rvalid    = 1'b0;
        dm_rdata     = 32'h0000_0000;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'h0000_0000;
        mem_wdata    = 32'h0000_0000;
        mem_wstrb    = 4'b0000;
        bus_err      = 1'b0;

        case (state)
            ST_IDLE: begin
                bus_err = mem_rvalid && !rst;
                if (if_req || dm_req) begin
                    owner_nxt    = pick_owner(if_req, dm_req, starve_at_max);
                    owner_we_nxt = (owner_nxt == OWN_DM) && dm_we;
                    state_nxt    = ST_ISSUE;
                    if ((owner_nxt == OWN_DM) && if_req) begin
                        starve_inc = 1'b1;
                    end else begin
                        starve_clr = 1'b1;
                    end
                end else begin
                    state_nxt = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                bus_err = mem_rvalid;
                mem_req = 1'b1;
                if (owner == OWN_DM) begin
                    mem_we    = dm_we;
                    mem_addr  = dm_addr;
                    mem_wdata = dm_wdata;
                    mem_wstrb = dm_we ? dm_wstrb : 4'b0000;
                end else begin
                    mem_addr  = if_addr;
                end
                // A withdrawn request aborts even if memory is ready this cycle.
                if (!owner_req) begin
                    state_nxt = ST_IDLE;
                end else if (mem_ready) begin
                    if_gnt    = (owner == OWN_IF);
                    dm_gnt    = (owner == OWN_DM);
                    state_nxt = ST_WAIT;
                end else begin
                    state_nxt = ST_ISSUE;
                end
            end

            ST_WAIT: begin
                if (mem_rvalid) begin
                    if (owner == OWN_DM) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = owner_we ? 32'h0000_0000 : mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                    state_nxt = ST_IDLE;
                end else if (tmo_hit) begin
                    if_rvalid = (owner == OWN_IF);
                    dm_rvalid = (owner == OWN_DM);
                    bus_err   = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX   = 4;
    localparam int WAIT_TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, dm_req, dm_we, mem_ready, mem_rvalid;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [3:0]  dm_wstrb;
    logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, bus_err;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .WAIT_TIMEOUT(WAIT_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are checked 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 32'h0; dm_req = 1'b0; dm_we = 1'b0;
        dm_addr = 32'h0; dm_wdata = 32'h0; dm_wstrb = 4'b0000;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_if_gnt"},    if_gnt, 32'd0);
        chk({tag, "_dm_gnt"},    dm_gnt, 32'd0);
        chk({tag, "_if_rvalid"}, if_rvalid, 32'd0);
        chk({tag, "_dm_rvalid"}, dm_rvalid, 32'd0);
        chk({tag, "_if_rdata"},  if_rdata, 32'd0);
        chk({tag, "_dm_rdata"},  dm_rdata, 32'd0);
        chk({tag, "_mem_req"},   mem_req, 32'd0);
        chk({tag, "_mem_addr"},  mem_addr, 32'd0);
        chk({tag, "_bus_err"},   bus_err, 32'd0);
    endtask

    // Reference model state for the randomized phase.
    logic [31:0] mem_arr [256];
    logic        if_pend, dm_pend, own_dm, rsp_own_dm, rsp_store, rsp_now;
    logic        prev_if, prev_dm, prev_mem_req;
    logic [31:0] rsp_data, exp_rd;
    int          rsp_cnt, starve_m, grants, if_wait, max_if_wait, n_tmo;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        #2;
        chk_all_quiet("reset");
        tick(); tick();
        rst = 1'b0;
        tick();

        // Single fetch with zero-wait memory.
        if_req = 1'b1; if_addr = 32'h0000_0100; mem_ready = 1'b1; #1;
        chk("fetch_c0_mem_req", mem_req, 32'd0);
        chk("fetch_c0_if_gnt",  if_gnt, 32'd0);
        tick(); #1;
        chk("fetch_c1_mem_req",   mem_req, 32'd1);
        chk("fetch_c1_mem_addr",  mem_addr, 32'h100);
        chk("fetch_c1_mem_we",    mem_we, 32'd0);
        chk("fetch_c1_mem_wstrb", mem_wstrb, 32'd0);
        chk("fetch_c1_if_gnt",    if_gnt, 32'd1);
        chk("fetch_c1_dm_gnt",    dm_gnt, 32'd0);
        tick();
        if_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013; #1;
        chk("fetch_c2_if_rvalid", if_rvalid, 32'd1);
        chk("fetch_c2_if_rdata",  if_rdata, 32'h13);
        chk("fetch_c2_dm_rvalid", dm_rvalid, 32'd0);
        chk("fetch_c2_dm_rdata",  dm_rdata, 32'd0);
        chk("fetch_c2_bus_err",   bus_err, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk_all_quiet("fetch_c3");

        // Both requesters always pending: starvation guard interleaves fetch.
        begin
            int k = 0;
            logic hs_prev = 1'b0;
            if_req = 1'b1; if_addr = 32'h0000_0400;
            dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0800;
            mem_ready = 1'b1;
            for (int c = 0; c < 100 && k < 10; c++) begin
                tick();
                mem_rvalid = hs_prev; #1;
                hs_prev = if_gnt || dm_gnt;
                if (if_gnt || dm_gnt) begin
                    chk($sformatf("grant%0d_if", k), if_gnt, (k % 5 == 4) ? 32'd1 : 32'd0);
                    chk($sformatf("grant%0d_dm", k), dm_gnt, (k % 5 == 4) ? 32'd0 : 32'd1);
                    k++;
                end
            end
            chk("grant_count", k, 32'd10);
            tick();
            if_req = 1'b0; dm_req = 1'b0; mem_rvalid = 1'b1; #1;
            tick();
            mem_rvalid = 1'b0;
        end

        // Store with memory back-pressure for three cycles.
        idle_inputs();
        tick();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0200;
        dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011; #1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            mem_ready = (c == 4); #1;
            chk($sformatf("store_c%0d_mem_req", c),   mem_req, 32'd1);
            chk($sformatf("store_c%0d_mem_we", c),    mem_we, 32'd1);
            chk($sformatf("store_c%0d_mem_addr", c),  mem_addr, 32'h200);
            chk($sformatf("store_c%0d_mem_wdata", c), mem_wdata, 32'hDEADBEEF);
            chk($sformatf("store_c%0d_mem_wstrb", c), mem_wstrb, 32'h3);
            chk($sformatf("store_c%0d_dm_gnt", c),    dm_gnt, (c == 4) ? 32'd1 : 32'd0);
        end
        tick();
        dm_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; #1;
        chk("store_rsp_dm_rvalid", dm_rvalid, 32'd1);
        chk("store_rsp_dm_rdata",  dm_rdata, 32'd0);
        chk("store_rsp_if_rvalid", if_rvalid, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        chk("store_after_dm_rvalid", dm_rvalid, 32'd0);

        // Memory never answers: timeout 64 cycles after the grant.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0500; mem_ready = 1'b1; #1;
        tick(); #1;
        chk("tmo_if_gnt", if_gnt, 32'd1);
        n_tmo = 0;
        begin
            logic seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                tick();
                if_req = 1'b0; mem_ready = 1'b0; #1;
                n_tmo++;
                seen = if_rvalid;
            end
        end
        chk("tmo_latency",   n_tmo, WAIT_TIMEOUT);
        chk("tmo_if_rvalid", if_rvalid, 32'd1);
        chk("tmo_if_rdata",  if_rdata, 32'd0);
        chk("tmo_bus_err",   bus_err, 32'd1);
        chk("tmo_dm_rvalid", dm_rvalid, 32'd0);
        tick(); #1;
        chk("tmo_after_bus_err", bus_err, 32'd0);

        // Reset during WAIT, then a late memory response.
        tick();
        if_req = 1'b1; if_addr = 32'h0000_0040; mem_ready = 1'b1; #1;
        tick(); #1;
        chk("rstwait_if_gnt", if_gnt, 32'd1);
        tick();
        if_req = 1'b0; mem_ready = 1'b0; #1;
        rst = 1'b1; #1;
        chk_all_quiet("rstwait_in_reset");
        tick();
        rst = 1'b0;
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_0055; #1;
        chk("late_rsp_if_rvalid", if_rvalid, 32'd0);
        chk("late_rsp_if_rdata",  if_rdata, 32'd0);
        chk("late_rsp_bus_err",   bus_err, 32'd1);
        chk("late_rsp_mem_req",   mem_req, 32'd0);
        tick();
        mem_rvalid = 1'b0; #1;
        chk("late_rsp_after_bus_err", bus_err, 32'd0);

        // Spurious response while idle.
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        chk("spur_bus_err",   bus_err, 32'd1);
        chk("spur_if_rvalid", if_rvalid, 32'd0);
        chk("spur_dm_rvalid", dm_rvalid, 32'd0);
        chk("spur_dm_rdata",  dm_rdata, 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Data request withdrawn before memory is ready.
        tick();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; #1;
        tick(); #1;
        chk("abort_issue_mem_req",  mem_req, 32'd1);
        chk("abort_issue_mem_addr", mem_addr, 32'h300);
        tick();
        dm_req = 1'b0; #1;
        chk("abort_drop_mem_req", mem_req, 32'd1);
        chk("abort_drop_dm_gnt",  dm_gnt, 32'd0);
        tick(); #1;
        chk("abort_after_mem_req", mem_req, 32'd0);
        chk("abort_after_dm_gnt",  dm_gnt, 32'd0);

        // Randomized traffic against a transaction-level reference.
        idle_inputs();
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        if_pend = 1'b0; dm_pend = 1'b0; own_dm = 1'b0; rsp_own_dm = 1'b0;
        rsp_store = 1'b0; rsp_data = 32'h0; rsp_cnt = 0; starve_m = 0;
        prev_if = 1'b0; prev_dm = 1'b0; prev_mem_req = 1'b0;
        grants = 0; if_wait = 0; max_if_wait = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            tick();
            if (!if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1;
                if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!dm_pend && $urandom_range(0, 1) == 0) begin
                dm_pend  = 1'b1;
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
                dm_wdata = $urandom;
                dm_wstrb = 4'($urandom_range(0, 15));
            end
            if_req = if_pend; dm_req = dm_pend;
            mem_ready = 1'($urandom_range(0, 1));
            mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rsp_data;
                end
            end
            rsp_now = mem_rvalid;
            #1;
            if (mem_req && !prev_mem_req) begin
                own_dm   = (prev_if && prev_dm) ? (starve_m < STARVE_MAX) : prev_dm;
                starve_m = (own_dm && prev_if) ?
                           ((starve_m < STARVE_MAX) ? starve_m + 1 : STARVE_MAX) : 0;
                chk("rnd_mem_addr",  mem_addr, own_dm ? dm_addr : if_addr);
                chk("rnd_mem_we",    mem_we, own_dm ? 32'(dm_we) : 32'd0);
                chk("rnd_mem_wstrb", mem_wstrb, (own_dm && dm_we) ? 32'(dm_wstrb) : 32'd0);
                if (own_dm && dm_we) chk("rnd_mem_wdata", mem_wdata, dm_wdata);
            end
            chk("rnd_if_gnt", if_gnt, (mem_req && mem_ready && !own_dm) ? 32'd1 : 32'd0);
            chk("rnd_dm_gnt", dm_gnt, (mem_req && mem_ready && own_dm) ? 32'd1 : 32'd0);
            if (mem_req && mem_ready) begin
                grants++;
                rsp_own_dm = own_dm;
                rsp_store  = own_dm && dm_we;
                rsp_cnt    = $urandom_range(1, 3);
                if (own_dm) begin
                    if (dm_we) begin
                        for (int b = 0; b < 4; b++)
                            if (dm_wstrb[b]) mem_arr[dm_addr[9:2]][8*b +: 8] = dm_wdata[8*b +: 8];
                        rsp_data = $urandom;
                    end else begin
                        rsp_data = mem_arr[dm_addr[9:2]];
                    end
                    dm_pend = 1'b0;
                end else begin
                    rsp_data = mem_arr[if_addr[9:2]];
                    if_pend  = 1'b0;
                end
            end
            if (rsp_now) begin
                exp_rd = rsp_store ? 32'h0 : rsp_data;
                chk("rnd_if_rvalid", if_rvalid, rsp_own_dm ? 32'd0 : 32'd1);
                chk("rnd_dm_rvalid", dm_rvalid, rsp_own_dm ? 32'd1 : 32'd0);
                chk("rnd_if_rdata",  if_rdata, rsp_own_dm ? 32'd0 : exp_rd);
                chk("rnd_dm_rdata",  dm_rdata, rsp_own_dm ? exp_rd : 32'd0);
            end else begin
                chk("rnd_if_rvalid_idle", if_rvalid, 32'd0);
                chk("rnd_dm_rvalid_idle", dm_rvalid, 32'd0);
            end
            chk("rnd_bus_err", bus_err, 32'd0);
            if_wait = if_pend ? if_wait + 1 : 0;
            if (if_wait > max_if_wait) max_if_wait = if_wait;
            prev_if = if_req; prev_dm = dm_req; prev_mem_req = mem_req;
        end
        chk("rnd_progress", (grants > 100) ? 32'd1 : 32'd0, 32'd1);
        chk("rnd_fetch_not_starved", (max_if_wait <= 200) ? 32'd1 : 32'd0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
